// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Writes are allowed when full if a read is accepted in the same cycle.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_accept;
   logic             rd_accept;

   // Flags come straight from the registered count, so they are glitch-free
   // and cannot both be high.
   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign rd_accept = rd_en && !empty;
   assign wr_accept = wr_en && (!full || rd_accept);

   // Storage is deliberately not reset; the pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (wr_accept && rstn) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
         end
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: stimulus queues hand-computed read data,
// a separate monitor pops and compares whenever an accepted read lands.
module tb_fifo;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       empty;
   logic       full;

   logic       rdFire;
   logic [7:0] expQ[$];
   int         compared;
   int         mismatched;

   fifo #(.WIDTH(8), .DEPTH(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .data_out (data_out),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: an accepted read presents its word just after the edge.
   initial begin
      logic fire;
      logic [7:0] exp;
      forever begin
         @(posedge clk);
         fire = rdFire;
         #1;
         if (fire) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL scoreboard_underrun actual=%0h required=<no pending word>", data_out);
            end else begin
               exp = expQ.pop_front();
               if (data_out !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL read_data actual=%0h required=%0h", data_out, exp);
               end
            end
         end
      end
   end

   // One clock cycle: drive at negedge, hold across the posedge, release after it.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] din,
                                input logic expectPop, input logic [7:0] popVal);
      @(negedge clk);
      wr_en   = wr;
      rd_en   = rd;
      data_in = din;
      rdFire  = expectPop;
      if (expectPop) expQ.push_back(popVal);
      @(posedge clk);
      #1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      rdFire = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic expEmpty, input logic expFull,
                              input logic [7:0] expData);
      compared++;
      if (empty !== expEmpty) begin
         mismatched++;
         $display("[TB] FAIL %s.empty actual=%b required=%b", name, empty, expEmpty);
      end
      compared++;
      if (full !== expFull) begin
         mismatched++;
         $display("[TB] FAIL %s.full actual=%b required=%b", name, full, expFull);
      end
      compared++;
      if (data_out !== expData) begin
         mismatched++;
         $display("[TB] FAIL %s.data_out actual=%0h required=%0h", name, data_out, expData);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rdFire     = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      data_in    = 8'h00;
      rstn       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset", 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      rstn = 1'b1;

      // Fill with 1..8
      applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'h00);
      checkOutput("fill_first", 1'b0, 1'b0, 8'h00);
      for (int i = 2; i <= 7; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 8'h00);
      checkOutput("fill_seventh", 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'd8, 1'b0, 8'h00);
      checkOutput("fill_full", 1'b0, 1'b1, 8'h00);

      // Overflow write is ignored
      applyStimulus(1'b1, 1'b0, 8'd9, 1'b0, 8'h00);
      checkOutput("overflow", 1'b0, 1'b1, 8'h00);

      // Drain 1..8
      for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'(i));
      checkOutput("drained", 1'b1, 1'b0, 8'd8);

      // Underflow read is ignored, output holds
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      checkOutput("underflow", 1'b1, 1'b0, 8'd8);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      checkOutput("idle_hold", 1'b1, 1'b0, 8'd8);

      // Simultaneous read and write while full
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h11 + i), 1'b0, 8'h00);
      checkOutput("refill", 1'b0, 1'b1, 8'd8);
      applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 8'h11);
      checkOutput("full_rw", 1'b0, 1'b1, 8'h11);
      for (int i = 1; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h11 + i));
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'hAA);
      checkOutput("full_rw_drain", 1'b1, 1'b0, 8'hAA);

      // Simultaneous read and write while empty: write only, no bypass
      applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
      checkOutput("empty_rw", 1'b0, 1'b0, 8'hAA);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'h55);
      checkOutput("empty_rw_read", 1'b1, 1'b0, 8'h55);

      // 20 write/read pairs wrap both pointers several times
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i * 7 + 3), 1'b0, 8'h00);
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'(i * 7 + 3));
      end
      checkOutput("wrap", 1'b1, 1'b0, 8'(19 * 7 + 3));

      // Reset mid-stream, away from any clock edge
      applyStimulus(1'b1, 1'b0, 8'h31, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h32, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 8'h00);
      #2;
      rstn = 1'b0;
      wr_en = 1'b1;
      rd_en = 1'b1;
      data_in = 8'h77;
      #1;
      checkOutput("async_reset", 1'b1, 1'b0, 8'h00);
      expQ.delete();
      @(posedge clk);
      #1;
      checkOutput("reset_ignores_req", 1'b1, 1'b0, 8'h00);

      // First edge after release accepts a write
      @(negedge clk);
      rstn    = 1'b1;
      wr_en   = 1'b1;
      rd_en   = 1'b0;
      data_in = 8'h44;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      checkOutput("post_reset_write", 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 8'h44);
      checkOutput("post_reset_read", 1'b1, 1'b0, 8'h44);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      checkOutput("no_stale_data", 1'b1, 1'b0, 8'h44);

      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two and >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  write request; data_in SHALL be captured on a rising edge when accepted.
REQ-006 rd_en  input  1  read request; the oldest entry SHALL be popped to data_out on a rising edge when accepted.
REQ-007 data_in  input  WIDTH  write data.
REQ-008 data_out  output  WIDTH  registered read data.
REQ-009 empty  output  1  high when the stored count is 0.
REQ-010 full  output  1  high when the stored count equals DEPTH.

Function
REQ-011 Ordering SHALL be strict first-in first-out; storage is DEPTH x WIDTH.
REQ-012 Internal state: write pointer, read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
REQ-013 Write accepted = wr_en and (not full, or rd_en accepted in the same cycle).
- On accept: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
REQ-014 Read accepted = rd_en and not empty.
- On accept: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Read latency: data valid on data_out after the same rising edge that accepts rd_en (one-cycle registered read).
REQ-015 data_out SHALL hold its last value in any cycle without an accepted read.
REQ-016 Write while full without a simultaneous read SHALL be ignored: no memory, pointer, count or flag change.
REQ-017 Read while empty SHALL be ignored.
- data_out holds its value.
- A simultaneous write SHALL still be accepted, so count becomes 1.
- The written word SHALL NOT be bypassed to data_out.
REQ-018 Simultaneous accepted read and write SHALL leave count unchanged; both pointers advance.
- When full, the popped word SHALL be the old oldest entry, never the word being written.
REQ-019 Count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
REQ-020 empty and full SHALL be decoded from the registered count and reflect the post-edge state in the cycle after the edge.
- empty and full SHALL never be high simultaneously.
REQ-021 Pointer wrap-around SHALL be seamless; ordering is preserved across any number of wraps.
REQ-022 Unknown or undriven data_in SHALL NOT affect flags or pointers.

Reset
REQ-023 rstn low SHALL immediately, independent of clk, force: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, data_out = 0.
REQ-024 Memory contents SHALL NOT be reset; they SHALL be unobservable until rewritten.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries; wr_en and rd_en SHALL be ignored while rstn is low.
REQ-026 After rstn deasserts, the first rising edge SHALL be able to accept a write.

Verification
REQ-027 Reset: hold rstn low with wr_en = rd_en = 0 -> empty = 1, full = 0, data_out = 0.
REQ-028 Fill: WIDTH = DEPTH = 8; write 1..8 on 8 consecutive edges -> empty falls after the first edge; full rises after the eighth edge.
REQ-029 Drain: then assert rd_en for 8 consecutive edges -> data_out = 1,2,...,8 in order, one edge each; empty = 1 and full = 0 after the eighth; data_out holds 8 afterwards.
REQ-030 Overflow/underflow:
- Write 9 when full -> ignored; reads return 1..8.
- rd_en when empty -> data_out unchanged, flags unchanged.
REQ-031 Simultaneous access:
- At full, wr_en and rd_en together with data_in = 0xAA -> data_out = oldest word; full stays 1; 0xAA is read last.
- At empty, wr_en and rd_en together -> count 1, data_out unchanged.
REQ-032 Wrap and reset:
- Run 20 interleaved write/read pairs -> output sequence equals input sequence.
- Assert rstn mid-stream -> immediate empty = 1, data_out = 0; prior data is never returned.
